// File: rtl/vga_text_ctrl.sv
// rtl/vga_text_ctrl.sv - text-mode console write controller: cursor, VRAM writes, scroll and clear
// Optional feature macro: VTC_AUTOCLR_EN (full-screen clear runs straight out of reset)
module vga_text_ctrl #(
    parameter int         COLS  = 70,
    parameter int         ROWS  = 30,
    parameter int         COL_W = 7,
    parameter int         ROW_W = 5,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_char,
    input  logic                     clr_req,
    output logic                     vram_we,
    output logic [ROW_W+COL_W-1:0]   vram_waddr,
    output logic [7:0]               vram_wdata,
    output logic [ROW_W-1:0]         row_base,
    output logic [COL_W-1:0]         cur_x,
    output logic [ROW_W-1:0]         cur_y,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLR_ROW,
        S_CLR_ALL
    } state_t;

`ifdef VTC_AUTOCLR_EN
    localparam state_t RESET_STATE = S_CLR_ALL;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROWS_C   = ROW_W'(ROWS);
    localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W+1)'(ROWS);

    state_t                   state_q,    state_d;
    logic [COL_W-1:0]         cur_x_q,    cur_x_d;
    logic [ROW_W-1:0]         cur_y_q,    cur_y_d;
    logic [ROW_W-1:0]         row_base_q, row_base_d;
    logic [ROW_W-1:0]         clr_row_q,  clr_row_d;
    logic [COL_W-1:0]         clr_col_q,  clr_col_d;
    logic                     scroll_q,   scroll_d;
    logic                     clr_pend_q, clr_pend_d;
    logic                     we_q,       we_d;
    logic [ROW_W+COL_W-1:0]   waddr_q,    waddr_d;
    logic [7:0]               wdata_q,    wdata_d;

    logic [ROW_W:0]           row_sum;
    logic [ROW_W-1:0]         phys_row;
    logic [ROW_W-1:0]         base_inc;
    logic                     printable;

    // Map the logical cursor row onto the physical VRAM row and precompute the scrolled base
    always_comb begin
        row_sum = {1'b0, cur_y_q} + {1'b0, row_base_q};
        if (row_sum >= ROWS_EXT) begin
            phys_row = ROW_W'(row_sum - ROWS_EXT);
        end else begin
            phys_row = row_sum[ROW_W-1:0];
        end
        base_inc  = (row_base_q == LAST_ROW) ? '0 : row_base_q + ROW_W'(1);
        printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
    end

    // Next-state, cursor and VRAM write decisions; a clear request always wins in IDLE
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;
        clr_row_d  = clr_row_q;
        clr_col_d  = clr_col_q;
        scroll_d   = scroll_q;
        clr_pend_d = clr_pend_q | clr_req;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        in_ready   = (state_q == S_IDLE) & ~clr_pend_q & ~clr_req;

        case (state_q)
            S_IDLE: begin
                if (clr_pend_q || clr_req) begin
                    // first cell is written on the entry edge, counters point at the next one
                    state_d    = S_CLR_ALL;
                    clr_pend_d = 1'b0;
                    row_base_d = '0;
                    cur_x_d    = '0;
                    cur_y_d    = '0;
                    we_d       = 1'b1;
                    waddr_d    = '0;
                    wdata_d    = BLANK;
                    clr_row_d  = '0;
                    clr_col_d  = COL_W'(1);
                end else if (in_valid) begin
                    state_d = S_WRITE;
                    if (printable) begin
                        we_d    = 1'b1;
                        waddr_d = {phys_row, cur_x_q};
                        wdata_d = in_char;
                        if (cur_x_q == LAST_COL) begin
                            cur_x_d = '0;
                            if (cur_y_q < LAST_ROW) begin
                                cur_y_d = cur_y_q + ROW_W'(1);
                            end else begin
                                // the character write owns this cycle; row blanking follows WRITE
                                scroll_d   = 1'b1;
                                clr_row_d  = row_base_q;
                                row_base_d = base_inc;
                            end
                        end else begin
                            cur_x_d = cur_x_q + COL_W'(1);
                        end
                    end else if (in_char == 8'h0A) begin
                        cur_x_d = '0;
                        if (cur_y_q < LAST_ROW) begin
                            cur_y_d = cur_y_q + ROW_W'(1);
                        end else begin
                            state_d    = S_CLR_ROW;
                            row_base_d = base_inc;
                            we_d       = 1'b1;
                            waddr_d    = {row_base_q, {COL_W{1'b0}}};
                            wdata_d    = BLANK;
                            clr_row_d  = row_base_q;
                            clr_col_d  = COL_W'(1);
                        end
                    end else if (in_char == 8'h0D) begin
                        cur_x_d = '0;
                    end else if (in_char == 8'h08) begin
                        if (cur_x_q != '0) begin
                            cur_x_d = cur_x_q - COL_W'(1);
                            we_d    = 1'b1;
                            waddr_d = {phys_row, cur_x_q - COL_W'(1)};
                            wdata_d = BLANK;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (scroll_q) begin
                    state_d   = S_CLR_ROW;
                    scroll_d  = 1'b0;
                    we_d      = 1'b1;
                    waddr_d   = {clr_row_q, {COL_W{1'b0}}};
                    wdata_d   = BLANK;
                    clr_col_d = COL_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLR_ROW: begin
                if (clr_col_q == COLS_C) begin
                    state_d = S_IDLE;
                end else begin
                    we_d      = 1'b1;
                    waddr_d   = {clr_row_q, clr_col_q};
                    wdata_d   = BLANK;
                    clr_col_d = clr_col_q + COL_W'(1);
                end
            end

            S_CLR_ALL: begin
                // counters run one past the last row; a new request re-enters from IDLE
                if (clr_row_q == ROWS_C) begin
                    state_d = S_IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = {clr_row_q, clr_col_q};
                    wdata_d = BLANK;
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row_q + ROW_W'(1);
                    end else begin
                        clr_col_d = clr_col_q + COL_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, cursor and VRAM port registers; reset aborts any clear immediately
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
            scroll_q   <= 1'b0;
            clr_pend_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
            scroll_q   <= scroll_d;
            clr_pend_q <= clr_pend_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign vram_we    = we_q;
    assign vram_waddr = waddr_q;
    assign vram_wdata = wdata_q;
    assign row_base   = row_base_q;
    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign busy       = (state_q == S_CLR_ROW) || (state_q == S_CLR_ALL);

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb/tb_vga_text_ctrl.sv - self-checking bench for vga_text_ctrl with a per-cycle slot model
module tb_vga_text_ctrl;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'h00;
    logic        clr_req = 1'b0;
    logic        vram_we;
    logic [11:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic [4:0]  row_base;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vga_text_ctrl dut (
        .pclk(pclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .clr_req(clr_req), .vram_we(vram_we), .vram_waddr(vram_waddr),
        .vram_wdata(vram_wdata), .row_base(row_base), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each busy cycle of the controller is one slot (a write or an idle step)
    typedef struct {
        bit we;
        int addr;
        int data;
        bit busy;
    } slot_t;

    slot_t q[$];
    int    mx = 0, my = 0, mbase = 0;
    bit    pend = 0;

    function automatic slot_t mk(input bit we, input int addr, input int data, input bit bsy);
        slot_t s;
        s.we = we; s.addr = addr; s.data = data; s.busy = bsy;
        return s;
    endfunction

    task automatic blank_row(input int prow);
        for (int c = 0; c < 70; c++) q.push_back(mk(1, prow * 128 + c, 8'h20, 1));
    endtask

    task automatic model_byte(input int ch);
        int phys;
        phys = (my + mbase) % 30;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            q.push_back(mk(1, phys * 128 + mx, ch, 0));
            if (mx == 69) begin
                mx = 0;
                if (my < 29) my++;
                else begin
                    blank_row(mbase);
                    mbase = (mbase + 1) % 30;
                end
            end else mx++;
        end else if (ch == 8'h0A) begin
            mx = 0;
            if (my < 29) begin
                my++;
                q.push_back(mk(0, 0, 0, 0));
            end else begin
                blank_row(mbase);
                mbase = (mbase + 1) % 30;
            end
        end else if (ch == 8'h08 && mx > 0) begin
            mx--;
            q.push_back(mk(1, phys * 128 + mx, 8'h20, 0));
        end else begin
            if (ch == 8'h0D) mx = 0;
            q.push_back(mk(0, 0, 0, 0));
        end
    endtask

    // Model advance on every clock edge from the inputs the DUT also sees
    always @(posedge pclk or posedge reset) begin
        bit was_idle;
        if (reset) begin
            q.delete();
            mx = 0; my = 0; mbase = 0; pend = 0;
        end else begin
            was_idle = (q.size() == 0);
            if (!was_idle) void'(q.pop_front());
            if (was_idle && (pend || clr_req)) begin
                pend = 0; mx = 0; my = 0; mbase = 0;
                for (int r = 0; r < 30; r++)
                    for (int c = 0; c < 70; c++) q.push_back(mk(1, r * 128 + c, 8'h20, 1));
            end else begin
                if (clr_req) pend = 1;
                if (was_idle && in_valid) model_byte(int'(in_char));
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge pclk) begin
        slot_t h;
        if (!reset) begin
            h = (q.size() > 0) ? q[0] : mk(0, 0, 0, 0);
            chk("m_we", int'(vram_we), int'(h.we));
            if (h.we) begin
                chk("m_waddr", int'(vram_waddr), h.addr);
                chk("m_wdata", int'(vram_wdata), h.data);
            end
            chk("m_in_ready", int'(in_ready), int'(q.size() == 0 && !pend && !clr_req));
            chk("m_busy", int'(busy), int'(h.busy));
            chk("m_cur_x", int'(cur_x), mx);
            chk("m_cur_y", int'(cur_y), my);
            chk("m_row_base", int'(row_base), mbase);
        end
    end

    // Callers sit at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(posedge pclk); #1;
            n++;
        end
        if (n >= 3000) chk("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge pclk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int cnt, bad, lo, last;

        repeat (3) @(posedge pclk);
        #1 reset = 1'b0;
        chk("rst_we", int'(vram_we), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cursor", int'({cur_y, cur_x}), 0);

        // 'A' at (0,0)
        send(8'h41);
        chk("a_we", int'(vram_we), 1);
        chk("a_waddr", int'(vram_waddr), 12'h000);
        chk("a_wdata", int'(vram_wdata), 8'h41);
        chk("a_cur_x", int'(cur_x), 1);
        @(posedge pclk); #1;
        chk("a_ready_cycle2", int'(in_ready), 1);

        // clear request beats a simultaneous byte
        clr_req = 1'b1; in_valid = 1'b1; in_char = 8'h5A;
        #1 chk("clr_blocks_ready", int'(in_ready), 0);
        @(posedge pclk); #1;
        clr_req = 1'b0; in_valid = 1'b0;
        cnt = 0; bad = 0; last = 0;
        for (int i = 0; i < 2200; i++) begin
            if (vram_we) begin
                cnt++;
                last = int'(vram_waddr);
                if (vram_wdata != 8'h20) bad++;
            end
            @(posedge pclk); #1;
        end
        chk("clr_count", cnt, 2100);
        chk("clr_last_addr", last, 12'hEC5);
        chk("clr_nonblank", bad, 0);
        chk("clr_cursor", int'({row_base, cur_y, cur_x}), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_ready", int'(in_ready), 1);

        // 70 'x' fill row 0 then wrap without scrolling
        last = 0;
        for (int i = 0; i < 70; i++) begin
            send(8'h78);
            last = int'(vram_waddr);
        end
        chk("x_last_addr", last, 12'h045);
        chk("x_cur_x", int'(cur_x), 0);
        chk("x_cur_y", int'(cur_y), 1);
        chk("x_row_base", int'(row_base), 0);

        // backspace mid-row and at column 0
        for (int i = 0; i < 5; i++) send(8'h62);
        send(8'h08);
        chk("bs_we", int'(vram_we), 1);
        chk("bs_waddr", int'(vram_waddr), 12'h084);
        chk("bs_wdata", int'(vram_wdata), 8'h20);
        chk("bs_cur_x", int'(cur_x), 4);
        send(8'h0D);
        send(8'h08);
        chk("bs0_we", int'(vram_we), 0);
        chk("bs0_cur_x", int'(cur_x), 0);
        send(8'h07);
        chk("ign_we", int'(vram_we), 0);
        chk("ign_cur_y", int'(cur_y), 1);

        // newline at the bottom scrolls and blanks old row 0
        for (int i = 0; i < 28; i++) send(8'h0A);
        chk("nl_cur_y", int'(cur_y), 29);
        send(8'h0A);
        chk("scr_row_base", int'(row_base), 1);
        chk("scr_cur_y", int'(cur_y), 29);
        chk("scr_busy", int'(busy), 1);
        cnt = 0; lo = 0;
        for (int i = 0; i < 75; i++) begin
            if (vram_we && vram_wdata == 8'h20 && vram_waddr[11:7] == 5'd0) cnt++;
            if (!in_ready) lo++;
            @(posedge pclk); #1;
        end
        chk("scr_writes", cnt, 70);
        chk("scr_ready_low", lo, 70);

        // wrap at the last row scrolls via the printable path
        for (int i = 0; i < 70; i++) send(8'h77);
        send(8'h0D);
        chk("wrap_row_base", int'(row_base), 2);
        chk("wrap_cur_y", int'(cur_y), 29);

        // reset 100 cycles into a full clear
        clr_req = 1'b1;
        @(posedge pclk); #1;
        clr_req = 1'b0;
        repeat (100) begin
            @(posedge pclk); #1;
        end
        chk("pre_rst_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_we", int'(vram_we), 0);
        chk("async_busy", int'(busy), 0);
        @(posedge pclk); #1;
        reset = 1'b0;
        chk("post_rst_ready", int'(in_ready), 1);
        repeat (3) @(posedge pclk);
        #1 chk("post_rst_we", int'(vram_we), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
